imem_access_arbiter: RTL and testbench

Sequencer and arbiter for the processor's single instruction-memory port. It shares the memory between the fetch path (PC-driven reads) and a program loader (word-serial writes), and holds the core in stall until a program image has been loaded. It sits between the PC/fetch logic, the loader front end and the instruction memory array, which is external to this block.

---
 rtl/imem_arb_pkg.sv | 6 +
 rtl/imem_access_arbiter_if.sv | 35 +++
 rtl/imem_access_arbiter.sv | 60 ++++++
 tb/tb_imem_access_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and constants for the instruction-memory arbiter
package imem_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} arb_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int LOAD_CNT_W = 8;
endpackage

// File: rtl/imem_access_arbiter_if.sv
// imem_access_arbiter_if: fetch, loader, memory and status signals of the arbiter
interface imem_access_arbiter_if #(
  parameter int INS_ADDRESS = 32,
  parameter int INS_W = 32
);
  import imem_arb_pkg::*;
  logic fetch_req;
  logic [INS_ADDRESS-1:0] fetch_addr;
  logic fetch_gnt;
  logic fetch_valid;
  logic [INS_W-1:0] fetch_instr;
  logic load_valid;
  logic load_ready;
  logic [INS_ADDRESS-1:0] load_addr;
  logic [INS_W-1:0] load_data;
  logic load_last;
  logic mem_we;
  logic [INS_ADDRESS-1:0] mem_addr;
  logic [INS_W-1:0] mem_wdata;
  logic [INS_W-1:0] mem_rdata;
  logic cpu_stall;
  logic load_done;
  logic [LOAD_CNT_W-1:0] load_count;
  logic err;
  modport slave (
    input fetch_req, fetch_addr, load_valid, load_addr, load_data, load_last, mem_rdata,
    output fetch_gnt, fetch_valid, fetch_instr, load_ready, mem_we, mem_addr, mem_wdata,
    output cpu_stall, load_done, load_count, err
  );
  modport master (
    output fetch_req, fetch_addr, load_valid, load_addr, load_data, load_last, mem_rdata,
    input fetch_gnt, fetch_valid, fetch_instr, load_ready, mem_we, mem_addr, mem_wdata,
    input cpu_stall, load_done, load_count, err
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares one instruction-memory port between fetch and program loader
module imem_access_arbiter
  import imem_arb_pkg::*;
#(
  parameter int INS_ADDRESS = 32,
  parameter int INS_W = 32,
  parameter int DEPTH = 72
) (
  input logic clk,
  input logic reset,
  imem_access_arbiter_if.slave bus
);
  localparam logic [INS_ADDRESS-1:0] LIMIT = INS_ADDRESS'(DEPTH);
  arb_state_t state, state_nx;
  logic accept, load_oor, fetch_oor;
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // next state: a loader beat in RUN preempts fetching and reopens the load
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.load_valid ? (bus.load_last ? DRAIN : LOAD) : IDLE;
      LOAD: state_nx = bus.load_valid && bus.load_last ? DRAIN : LOAD;
      DRAIN: state_nx = RUN;
      RUN: state_nx = bus.load_valid ? LOAD : RUN;
      default: state_nx = IDLE;
    endcase
  end
  // handshake, stall and memory port steering
  always_comb begin
    bus.load_ready = (state == IDLE) || (state == LOAD);
    accept = bus.load_valid && bus.load_ready;
    bus.fetch_gnt = (state == RUN) && bus.fetch_req && !bus.load_valid;
    bus.cpu_stall = (state != RUN) || bus.load_valid;
    load_oor = bus.load_addr >= LIMIT;
    fetch_oor = bus.fetch_addr >= LIMIT;
    bus.mem_we = accept && !load_oor;
    bus.mem_addr = accept ? bus.load_addr : bus.fetch_addr;
    bus.mem_wdata = bus.load_data;
  end
  // registered fetch result, load bookkeeping and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.fetch_valid <= 1'b0;
      bus.fetch_instr <= '0;
      bus.load_done <= 1'b0;
      bus.load_count <= '0;
      bus.err <= 1'b0;
    end else begin
      bus.fetch_valid <= bus.fetch_gnt;
      if (bus.fetch_gnt) bus.fetch_instr <= fetch_oor ? INS_W'(NOP_INSTR) : bus.mem_rdata;
      bus.load_done <= accept && bus.load_last;
      bus.load_count <= (state == RUN && bus.load_valid) ? '0
                      : (state == IDLE && accept) ? LOAD_CNT_W'(1)
                      : (accept && bus.load_count != '1) ? bus.load_count + LOAD_CNT_W'(1)
                      : bus.load_count;
      bus.err <= bus.err | (accept && load_oor) | (bus.fetch_gnt && fetch_oor);
    end
  end
endmodule

// File: tb/tb_imem_access_arbiter.sv
// tb_imem_access_arbiter: scoreboard bench for the instruction-memory arbiter
module tb_imem_access_arbiter;
  typedef struct {logic [31:0] d; int c;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic [31:0] mem [72];
  logic [31:0] ref_mem [72];
  imem_access_arbiter_if bus ();
  imem_access_arbiter #(.INS_ADDRESS(32), .INS_W(32), .DEPTH(72)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // cycle counter used to time-stamp expected fetch results
  always @(posedge clk) cyc <= cyc + 1;
  // external memory array with combinational read
  always @(posedge clk) if (bus.mem_we && bus.mem_addr < 72) mem[bus.mem_addr[6:0]] <= bus.mem_wdata;
  assign bus.mem_rdata = bus.mem_addr < 72 ? mem[bus.mem_addr[6:0]] : 32'h0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask
  // fetch-result monitor: pops the scoreboard when a result is due
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].c == cyc) begin
        chk("fv_due", bus.fetch_valid, 1);
        chk("fetch_instr", bus.fetch_instr, sb[0].d);
        void'(sb.pop_front());
      end else begin
        chk("fv_idle", bus.fetch_valid, 0);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic fr, input logic [31:0] fa, input logic lv,
                     input logic [31:0] la, input logic [31:0] ld, input logic ll);
    bus.fetch_req = fr;
    bus.fetch_addr = fa;
    bus.load_valid = lv;
    bus.load_addr = la;
    bus.load_data = ld;
    bus.load_last = ll;
  endtask
  task automatic idle();
    set(0, 0, 0, 0, 0, 0);
    next();
  endtask
  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last);
    set(0, 0, 1, a, d, last);
    @(negedge clk);
    chk("beat_rdy", bus.load_ready, 1);
    chk("beat_we", bus.mem_we, a < 72);
    chk("beat_addr", bus.mem_addr, a);
    chk("beat_wdata", bus.mem_wdata, d);
    chk("beat_stall", bus.cpu_stall, 1);
    if (a < 72) ref_mem[a[6:0]] = d;
    next();
  endtask
  task automatic fetch(input logic [31:0] a, input logic exp_gnt);
    set(1, a, 0, 0, 0, 0);
    if (exp_gnt) sb.push_back('{d: (a < 72) ? ref_mem[a[6:0]] : 32'h0000_0013, c: cyc + 1});
    @(negedge clk);
    chk("fetch_gnt", bus.fetch_gnt, exp_gnt);
    chk("fetch_stall", bus.cpu_stall, !exp_gnt);
    chk("fetch_done", bus.load_done, 0);
    next();
  endtask
  initial begin
    set(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_stall", bus.cpu_stall, 1);
    chk("rst_ready", bus.load_ready, 1);
    chk("rst_done", bus.load_done, 0);
    chk("rst_cnt", bus.load_count, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_instr", bus.fetch_instr, 0);
    next();
    beat(0, 32'h0020_0093, 0);
    beat(4, 32'h0010_0113, 0);
    beat(8, 32'h0030_0193, 1);
    set(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_done", bus.load_done, 1);
    chk("drain_cnt", bus.load_count, 3);
    chk("drain_rdy", bus.load_ready, 0);
    chk("drain_stall", bus.cpu_stall, 1);
    chk("drain_gnt", bus.fetch_gnt, 0);
    next();
    fetch(0, 1);
    fetch(4, 1);
    fetch(8, 1);
    idle();
    idle();
    set(1, 0, 1, 12, 32'hAAAA_0001, 0);
    @(negedge clk);
    chk("pre_gnt", bus.fetch_gnt, 0);
    chk("pre_stall", bus.cpu_stall, 1);
    chk("pre_rdy", bus.load_ready, 0);
    chk("pre_we", bus.mem_we, 0);
    next();
    chk("pre_cnt0", bus.load_count, 0);
    beat(12, 32'h0050_0293, 0);
    beat(80, 32'h1234_5678, 1);
    set(1, 12, 0, 0, 0, 0);
    @(negedge clk);
    chk("d2_cnt", bus.load_count, 2);
    chk("d2_done", bus.load_done, 1);
    chk("d2_err", bus.err, 1);
    chk("d2_gnt", bus.fetch_gnt, 0);
    next();
    fetch(12, 1);
    fetch(100, 1);
    idle();
    fetch(0, 1);
    idle();
    idle();
    chk("err_sticky", bus.err, 1);
    reset = 1'b1;
    next();
    reset = 1'b0;
    beat(16, 32'h0070_0393, 0);
    beat(20, 32'h0080_0413, 0);
    reset = 1'b1;
    set(0, 0, 0, 0, 0, 0);
    next();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_cnt", bus.load_count, 0);
    chk("abort_done", bus.load_done, 0);
    chk("abort_stall", bus.cpu_stall, 1);
    chk("abort_rdy", bus.load_ready, 1);
    chk("abort_err", bus.err, 0);
    next();
    beat(24, 32'h0090_0493, 1);
    set(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("one_cnt", bus.load_count, 1);
    chk("one_done", bus.load_done, 1);
    chk("one_rdy", bus.load_ready, 0);
    next();
    fetch(24, 1);
    fetch(20, 1);
    fetch(4, 1);
    idle();
    idle();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
